// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants and FSM state type for the regfile burst reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REGFILE_ADDR_W = 12;
    localparam int REGFILE_DEPTH  = 1 << REGFILE_ADDR_W;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    // Accumulator wide enough for a full-depth burst of maximum-valued words.
    function automatic int sum_width(input int data_w, input int addr_w);
        return data_w + addr_w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_out_stage.sv
// ============================================================================
// Module   : rd_out_stage
// Brief    : Single-entry valid/ready holding register (load, hold, clear).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_out_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  slot_free
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last_q, last_d;

    assign slot_free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            addr_d  = in_addr;
            last_d  = in_last;
        end else if (valid_q && out_ready) begin
            // Payload is left in place; only the valid flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;

endmodule

`default_nettype wire

// File: rtl/regfile_burst_reader.sv
// ============================================================================
// Module   : regfile_burst_reader
// Brief    : Burst reader for the regfile random-read port with valid/ready
//            output stream. Optional running sum enabled by BURST_READER_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_burst_reader
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = REGFILE_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
`ifdef BURST_READER_SUM_EN
    ,
    output logic [sum_width(DATA_WIDTH, ADDR_WIDTH)-1:0] sum
`endif
);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  done_q, done_d;
    logic                  slot_free;
    logic                  load;
    logic                  issue_last;
    logic                  cmd_accept;

    assign issue_last = (remain_q == (ADDR_WIDTH+1)'(1));

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        done_d      = 1'b0;
        cmd_ready   = 1'b0;
        cmd_accept  = 1'b0;
        mem_re      = 1'b0;
        load        = 1'b0;
        case (state_q)
            RD_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_accept = 1'b1;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        next_addr_d = cmd_base;
                        remain_d    = cmd_len;
                        state_d     = RD_RUN;
                    end
                end
            end
            RD_RUN: begin
                // Reads are issued only into a free slot so none is lost or repeated.
                if (slot_free) begin
                    mem_re      = 1'b1;
                    load        = 1'b1;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remain_d    = remain_q - (ADDR_WIDTH+1)'(1);
                    if (issue_last) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            next_addr_q <= '0;
            remain_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr = next_addr_q;
    assign busy     = (state_q != RD_IDLE);
    assign done     = done_q;

    rd_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_data   (mem_data),
        .in_addr   (next_addr_q),
        .in_last   (issue_last),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_addr  (m_addr),
        .out_last  (m_last),
        .slot_free (slot_free)
    );

`ifdef BURST_READER_SUM_EN
    localparam int SUM_W = sum_width(DATA_WIDTH, ADDR_WIDTH);

    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (cmd_accept) begin
            sum_d = '0;
        end else if (m_valid && m_ready) begin
            sum_d = sum_q + SUM_W'(m_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_burst_reader.sv
// ============================================================================
// Module   : tb_regfile_burst_reader
// Brief    : Directed self-checking bench for regfile_burst_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_burst_reader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_base;
    logic [12:0] cmd_len;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [11:0] m_addr;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef BURST_READER_SUM_EN
    logic [20:0] sum;
`endif

    logic [7:0] rf [0:4095];
    int vectors;
    int miscompares;

    assign mem_data = rf[mem_addr];

    regfile_burst_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
`ifdef BURST_READER_SUM_EN
        ,
        .sum       (sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [11:0] base, input int len);
        logic [11:0] a;
        cmd_base  = base;
        cmd_len   = 13'(len);
        cmd_valid = 1'b1;
        m_ready   = 1'b1;
        #1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("run_busy", {31'd0, busy}, 1);
        chk("run_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("run_mem_re", {31'd0, mem_re}, 1);
        chk("run_mem_addr", {20'd0, mem_addr}, {20'd0, base});
        chk("first_no_valid", {31'd0, m_valid}, 0);
        for (int k = 0; k < len; k++) begin
            tick();
            a = base + 12'(k);
            chk("word_valid", {31'd0, m_valid}, 1);
            chk("word_data", {24'd0, m_data}, {24'd0, rf[a]});
            chk("word_addr", {20'd0, m_addr}, {20'd0, a});
            chk("word_last", {31'd0, m_last}, (k == len - 1) ? 32'd1 : 32'd0);
            chk("word_mem_re", {31'd0, mem_re}, (k < len - 1) ? 32'd1 : 32'd0);
            chk("word_no_done", {31'd0, done}, 0);
        end
        tick();
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_m_valid", {31'd0, m_valid}, 0);
        chk("done_busy", {31'd0, busy}, 0);
        tick();
        chk("done_clear", {31'd0, done}, 0);
    endtask

    initial begin
        logic [3:0]  pat;
        logic [11:0] a;
        logic        prev_stall;
        logic [7:0]  prev_data;
        int          k;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4096; i++) rf[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 4; i++) rf[12'h010 + i] = 8'hA0 + 8'(i);
        rf[12'hFFE] = 8'h3C;
        rf[12'hFFF] = 8'hC3;
        rf[12'h000] = 8'h5A;
        rf[12'h001] = 8'hA5;
        rf[12'h100] = 8'h01;
        rf[12'h101] = 8'hFF;
        rf[12'h102] = 8'h80;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_mem_re", {31'd0, mem_re}, 0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 0);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_data", {24'd0, m_data}, 0);
        chk("rst_m_addr", {20'd0, m_addr}, 0);
        chk("rst_m_last", {31'd0, m_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic burst A0..A3 then a wrapping burst across the top of the array.
        run_burst(12'h010, 4);
        run_burst(12'hFFE, 4);

        // Backpressure with m_ready pattern 1,0,0,1 repeating.
        pat       = 4'b1001;
        cmd_base  = 12'h020;
        cmd_len   = 13'd6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        k          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            tick();
            m_ready = pat[c % 4];
            #1;
            if (prev_stall) chk("bp_hold", {24'd0, m_data}, {24'd0, prev_data});
            if (m_valid) begin
                a = 12'h020 + 12'(k);
                chk("bp_data", {24'd0, m_data}, {24'd0, rf[a]});
                chk("bp_addr", {20'd0, m_addr}, {20'd0, a});
                chk("bp_last", {31'd0, m_last}, (k == 5) ? 32'd1 : 32'd0);
                if (!m_ready) chk("bp_mem_re_stall", {31'd0, mem_re}, 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) k++;
        end
        chk("bp_count", k, 6);
        m_ready = 1'b1;
        tick();
        chk("bp_done", {31'd0, done}, 1);
        tick();

        // Zero-length command.
        cmd_base  = 12'h123;
        cmd_len   = 13'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("len0_done", {31'd0, done}, 1);
        chk("len0_mem_re", {31'd0, mem_re}, 0);
        chk("len0_m_valid", {31'd0, m_valid}, 0);
        chk("len0_cmd_ready", {31'd0, cmd_ready}, 1);
        tick();
        chk("len0_done_clear", {31'd0, done}, 0);
        chk("len0_busy", {31'd0, busy}, 0);

        // Asynchronous reset after the second word is visible.
        cmd_base  = 12'h030;
        cmd_len   = 13'd6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("abort_pre_data", {24'd0, m_data}, {24'd0, rf[12'h031]});
        rst = 1'b1;
        #1;
        chk("abort_m_valid", {31'd0, m_valid}, 0);
        chk("abort_m_data", {24'd0, m_data}, 0);
        chk("abort_m_addr", {20'd0, m_addr}, 0);
        chk("abort_m_last", {31'd0, m_last}, 0);
        chk("abort_mem_re", {31'd0, mem_re}, 0);
        chk("abort_mem_addr", {20'd0, mem_addr}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("abort_no_done", {31'd0, done}, 0);
        chk("abort_idle_valid", {31'd0, m_valid}, 0);
        run_burst(12'h040, 2);

`ifdef BURST_READER_SUM_EN
        run_burst(12'h100, 3);
        chk("sum_total", {11'd0, sum}, 32'h180);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_burst_reader.md
Name: regfile_burst_reader

Overview:
- Bus-master reader for the regfile random-read port.
- Accepts a burst command (base address, length), drives `ran_re`/`ran_r_addr` into the regfile, and captures the combinational `ran_r_data`.
- Presents each word on a valid/ready output stream with address and last tag.
- Sits between the regfile and downstream compute/DMA logic that consumes stored operands in order.

Parameters:
- DATA_WIDTH, 8, width of the regfile word and the output stream data.
- ADDR_WIDTH, 12, regfile address width; depth is 2^ADDR_WIDTH = 4096.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  burst command offered.
- cmd_ready  output  1  reader can accept a command; high only in IDLE.
- cmd_base  input  ADDR_WIDTH  first regfile address of the burst.
- cmd_len  input  ADDR_WIDTH+1  word count, 0..4096; 0 is a no-op.
- mem_re  output  1  drives the regfile `ran_re`.
- mem_addr  output  ADDR_WIDTH  drives the regfile `ran_r_addr`.
- mem_data  input  DATA_WIDTH  from the regfile `ran_r_data`, combinational, same cycle as mem_addr.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_WIDTH  output word.
- m_addr  output  ADDR_WIDTH  regfile address of m_data.
- m_last  output  1  m_data is the final word of the burst.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=1; mem_re=0; mem_addr=0; m_valid=0; m_data=0; m_addr=0; m_last=0; busy=0; done=0; counters cleared.
- Reset mid-burst aborts immediately with no done pulse. The output word in flight is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_valid & cmd_len≠0: latch next_addr=cmd_base and remain=cmd_len, go to RUN.
  - cmd_valid & cmd_len=0: consume the command, pulse done next cycle, stay IDLE.
- RUN:
  - Define slot_free = !m_valid | m_ready.
  - mem_re = slot_free and mem_addr = next_addr, both combinational from registered state. mem_addr holds next_addr even when mem_re=0.
  - When mem_re=1, on the clock edge: m_data←mem_data, m_addr←next_addr, m_valid←1, m_last←(remain==1), next_addr←next_addr+1, remain←remain−1.
  - Address arithmetic is modulo 2^ADDR_WIDTH: 4095+1 wraps to 0.
  - Issuing the word with remain==1 moves the FSM to DRAIN.
- DRAIN: no reads. When m_valid & m_ready & m_last: m_valid←0, done pulses on the following cycle, go to IDLE.
- Output register:
  - Holds its value while m_valid & !m_ready.
  - m_data, m_addr and m_last are stable until the handshake.
  - Cleared to m_valid=0 on handshake when no new word is loaded.
- Throughput: 1 word/cycle with m_ready held high.
- Latency: first m_valid is 2 cycles after the cmd handshake (cycle 1 RUN issue, cycle 2 word visible).
- Total cycles for N words with m_ready=1: N+1 from cmd accept to last handshake, then done on the next cycle.
- Backpressure: mem_re drops whenever the slot is full and not draining, so no read is ever lost or duplicated.
- Commands: cmd_valid while busy is ignored (cmd_ready=0); the command must be held until accepted.
- Addresses at or above the regfile's fill level return 0 from the regfile. The reader forwards them unchanged and performs no checking.
- cmd_len=4096 reads the full array exactly once, wrapping from base.

Optional Feature:
- Macro: BURST_READER_SUM_EN.
- When defined:
  - Adds output `sum` (DATA_WIDTH+ADDR_WIDTH+1 bits, reset 0).
  - sum clears on cmd accept and accumulates m_data on every output handshake.
  - sum is valid when done pulses and holds until the next accept.
- When undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Package `regfile_pkg`:
  - Constant REGFILE_ADDR_W=12 and REGFILE_DEPTH=4096.
  - Enum rd_state_t {RD_IDLE, RD_RUN, RD_DRAIN}.
  - Optional SUM width constant.
- Sub-module `rd_out_stage`: single-entry valid/ready holding register with load, hold and clear. Ports: data, addr and last; exposes slot_free.
- FSM, counters and the optional sum stay in the top.

Test Plan:
- Burst base=0x010, len=4, m_ready=1, regfile holding 0xA0..0xA3 at 0x010..0x013 → m_data A0,A1,A2,A3; m_addr 0x010..0x013; m_last only on A3; done 1 cycle after; 5 cycles from accept to last.
- Wrap: base=0xFFE, len=4 → m_addr sequence FFE, FFF, 000, 001; data matches the regfile.
- Backpressure: len=6, m_ready toggling 1,0,0,1… → every word delivered exactly once, in order. m_data stays stable while stalled; mem_re=0 during the stall cycles.
- len=0 command → no mem_re, no m_valid, done pulses once, cmd_ready stays 1.
- Async rst asserted mid-burst after word 2 → all outputs at reset values immediately, no done. A following len=2 burst completes correctly.
- BURST_READER_SUM_EN: burst of 0x01, 0xFF, 0x80 → sum=0x180 at done.
